// File: rtl/mem_stage_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_pipe_if : EX->MS->WB handshake, data response and forwarding bus |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_stage_pipe_if #(
    parameter int RF_AW     = 5,
    parameter int PC_W      = 32,
    parameter int ES_BUS_W  = 5 + RF_AW + 2 * PC_W,
    parameter int MS_BUS_W  = 1 + RF_AW + 32 + PC_W,
    parameter int FWD_BUS_W = 2 + RF_AW + 32
);
    logic                 es_to_ms_valid;
    logic                 ms_allowin;
    logic [ES_BUS_W-1:0]  es_to_ms_bus;
    logic                 ms_to_ws_valid;
    logic                 ws_allowin;
    logic [MS_BUS_W-1:0]  ms_to_ws_bus;
    logic                 data_sram_data_ok;
    logic [31:0]          data_sram_rdata;
    logic [FWD_BUS_W-1:0] ms_fwd_bus;

    // The memory stage itself.
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );

    // The surrounding pipeline (EX, WB, data SRAM, ID).
    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_pipe : pipelined LoongArch memory stage with load response buffer |
// | Optional macro MS_SUBWORD_EN enables sub-word load extraction/extension.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_stage_pipe #(
    parameter int RF_AW    = 5,
    parameter int PC_W     = 32,
    parameter int ES_BUS_W = 5 + RF_AW + 2 * PC_W,
    parameter int MS_BUS_W = 1 + RF_AW + 32 + PC_W
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    mem_stage_pipe_if.slave   ms
);

    logic                r_ms_valid;
    logic [ES_BUS_W-1:0] r_bus;
    logic [31:0]         r_rbuf;
    logic                r_rbuf_vld;

    logic [2:0]          w_mem_op;
    logic                w_ld_req;
    logic                w_gr_we;
    logic [RF_AW-1:0]    w_dest;
    logic [PC_W-1:0]     w_alu;
    logic [PC_W-1:0]     w_pc;
    logic                w_ms_wait;
    logic                w_ready_go;
    logic                w_leave;
    logic                w_accept;
    logic [31:0]         w_word;
    logic [31:0]         w_load;
    logic [31:0]         w_alu32;
    logic [31:0]         w_final;
    logic [MS_BUS_W-1:0] w_ms_to_ws_bus;

    assign w_mem_op = r_bus[ES_BUS_W-1 -: 3];
    assign w_ld_req = r_bus[ES_BUS_W-4];
    assign w_gr_we  = r_bus[ES_BUS_W-5];
    assign w_dest   = r_bus[2*PC_W +: RF_AW];
    assign w_alu    = r_bus[PC_W +: PC_W];
    assign w_pc     = r_bus[0 +: PC_W];

    assign w_ms_wait  = r_ms_valid & w_ld_req & ~r_rbuf_vld;
    assign w_ready_go = ~w_ms_wait | ms.data_sram_data_ok;
    assign w_leave    = r_ms_valid & w_ready_go & ms.ws_allowin;
    assign w_accept   = ms.es_to_ms_valid & ms.ms_allowin;

    assign ms.ms_allowin     = ~r_ms_valid | (w_ready_go & ms.ws_allowin);
    assign ms.ms_to_ws_valid = r_ms_valid & w_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid <= 1'b0;
            r_bus      <= '0;
        end else if (w_accept) begin
            r_ms_valid <= 1'b1;
            r_bus      <= ms.es_to_ms_bus;
        end else if (w_ready_go & ms.ws_allowin) begin
            r_ms_valid <= 1'b0;
        end
    end

    // Park the response only when WB stalls; otherwise it passes straight through.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rbuf     <= '0;
            r_rbuf_vld <= 1'b0;
        end else if (w_leave) begin
            r_rbuf_vld <= 1'b0;
        end else if (w_ms_wait & ms.data_sram_data_ok & ~ms.ws_allowin) begin
            r_rbuf     <= ms.data_sram_rdata;
            r_rbuf_vld <= 1'b1;
        end
    end

    assign w_word = r_rbuf_vld ? r_rbuf : ms.data_sram_rdata;

`ifdef MS_SUBWORD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = w_word[7:0];
        case (w_alu[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = w_alu[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        case (w_mem_op)
            3'b001:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b010:  w_load = {{16{w_half[15]}}, w_half};
            3'b011:  w_load = {24'd0, w_byte};
            3'b100:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end
`else
    // Word-only build: the opcode carries no information here.
    logic w_unused_mem_op;
    assign w_unused_mem_op = ^w_mem_op;
    assign w_load          = w_word;
`endif

    generate
        if (PC_W > 32) begin : g_alu_trunc
            logic w_unused_alu_hi;
            assign w_unused_alu_hi = ^w_alu[PC_W-1:32];
            assign w_alu32         = w_alu[31:0];
        end else if (PC_W == 32) begin : g_alu_full
            assign w_alu32 = w_alu;
        end else begin : g_alu_zext
            assign w_alu32 = {{(32-PC_W){1'b0}}, w_alu};
        end
    endgenerate

    assign w_final = w_ld_req ? w_load : w_alu32;

    assign w_ms_to_ws_bus  = {w_gr_we, w_dest, w_final, w_pc};
    assign ms.ms_to_ws_bus = w_ms_to_ws_bus;
    assign ms.ms_fwd_bus   = {r_ms_valid & w_gr_we,
                              w_ms_wait & ~ms.data_sram_data_ok,
                              w_dest, w_final};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage_pipe : directed self-checking bench for mem_stage_pipe         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mem_stage_pipe;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fails;

    mem_stage_pipe_if #(.RF_AW(5), .PC_W(32)) bus_if ();

    mem_stage_pipe #(.RF_AW(5), .PC_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ms     (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire [31:0] ws_result = bus_if.ms_to_ws_bus[63:32];
    wire [31:0] ws_pc     = bus_if.ms_to_ws_bus[31:0];
    wire        fwd_we    = bus_if.ms_fwd_bus[38];
    wire        ld_blk    = bus_if.ms_fwd_bus[37];

    function automatic logic [73:0] mk_es(input logic [2:0] op, input logic ld,
                                          input logic we, input logic [4:0] dst,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {op, ld, we, dst, alu, pc};
    endfunction

    task automatic drive_idle();
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.es_to_ms_bus      = '0;
        bus_if.ws_allowin        = 1'b1;
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        resetn = 1'b0;
        #2;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset_valid: got %b want 0", bus_if.ms_to_ws_valid);
        end
        n_checks++;
        if (bus_if.ms_allowin !== 1'b1) begin
            n_fails++; $display("FAIL reset_allowin: got %b want 1", bus_if.ms_allowin);
        end
        n_checks++;
        if (bus_if.ms_fwd_bus !== 39'd0) begin
            n_fails++; $display("FAIL reset_fwd: got %h want 0", bus_if.ms_fwd_bus);
        end
        n_checks++;
        if (bus_if.ms_to_ws_bus !== 70'd0) begin
            n_fails++; $display("FAIL reset_wsbus: got %h want 0", bus_if.ms_to_ws_bus);
        end
        #1 resetn = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs  [3] = '{32'h1c000000, 32'h1c000004, 32'h1c000008};
        logic [31:0] alus [3] = '{32'h00000100, 32'h00000200, 32'hFFFF0300};
        for (int i = 0; i <= 3; i++) begin
            @(posedge clk); #1;
            bus_if.ws_allowin = 1'b1;
            if (i < 3) begin
                bus_if.es_to_ms_valid = 1'b1;
                bus_if.es_to_ms_bus   = mk_es(3'd0, 1'b0, 1'b1, 5'(i + 1), alus[i], pcs[i]);
            end else begin
                bus_if.es_to_ms_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (bus_if.ms_allowin !== 1'b1) begin
                n_fails++; $display("FAIL b2b_allowin[%0d]: got %b want 1", i, bus_if.ms_allowin);
            end
            if (i > 0) begin
                n_checks++;
                if (bus_if.ms_to_ws_valid !== 1'b1) begin
                    n_fails++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus_if.ms_to_ws_valid);
                end
                n_checks++;
                if (ws_result !== alus[i-1]) begin
                    n_fails++; $display("FAIL b2b_result[%0d]: got %h want %h", i, ws_result, alus[i-1]);
                end
                n_checks++;
                if (ws_pc !== pcs[i-1]) begin
                    n_fails++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, ws_pc, pcs[i-1]);
                end
            end
        end
        @(posedge clk); #2;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b0) begin
            n_fails++; $display("FAIL b2b_drain: got %b want 0", bus_if.ms_to_ws_valid);
        end
    endtask

    task automatic test_load_wait();
        @(posedge clk); #1;
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk_es(3'd0, 1'b1, 1'b1, 5'd7, 32'h00001000, 32'h1c000010);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            bus_if.es_to_ms_valid    = 1'b0;
            bus_if.data_sram_data_ok = 1'b0;
            #1;
            n_checks++;
            if (ld_blk !== 1'b1 || fwd_we !== 1'b1) begin
                n_fails++; $display("FAIL ldw_blk[%0d]: got blk=%b we=%b want 1 1", c, ld_blk, fwd_we);
            end
            n_checks++;
            if (bus_if.ms_allowin !== 1'b0 || bus_if.ms_to_ws_valid !== 1'b0) begin
                n_fails++; $display("FAIL ldw_stall[%0d]: got allowin=%b valid=%b want 0 0",
                                    c, bus_if.ms_allowin, bus_if.ms_to_ws_valid);
            end
        end
        @(posedge clk); #1;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h12345678;
        #1;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b1 || ld_blk !== 1'b0 || bus_if.ms_allowin !== 1'b1) begin
            n_fails++; $display("FAIL ldw_go: got valid=%b blk=%b allowin=%b want 1 0 1",
                                bus_if.ms_to_ws_valid, ld_blk, bus_if.ms_allowin);
        end
        n_checks++;
        if (ws_result !== 32'h12345678) begin
            n_fails++; $display("FAIL ldw_result: got %h want 12345678", ws_result);
        end
        @(posedge clk); #1;
        bus_if.data_sram_data_ok = 1'b0;
        #1;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b0) begin
            n_fails++; $display("FAIL ldw_after: got %b want 0", bus_if.ms_to_ws_valid);
        end
    endtask

    task automatic test_subword();
        logic [2:0]  ops  [5] = '{3'd1, 3'd4, 3'd2, 3'd3, 3'd7};
        logic [31:0] adrs [5] = '{32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1001};
`ifdef MS_SUBWORD_EN
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h000080AA, 32'hFFFFBBCC, 32'h000000BB, 32'h80AABBCC};
`else
        logic [31:0] exps [5] = '{32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC};
`endif
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus_if.data_sram_data_ok = 1'b0;
            bus_if.es_to_ms_valid    = 1'b1;
            bus_if.es_to_ms_bus      = mk_es(ops[i], 1'b1, 1'b1, 5'd3, adrs[i], 32'h1c000100);
            @(posedge clk); #1;
            bus_if.es_to_ms_valid    = 1'b0;
            bus_if.data_sram_data_ok = 1'b1;
            bus_if.data_sram_rdata   = 32'h80AABBCC;
            #1;
            n_checks++;
            if (bus_if.ms_to_ws_valid !== 1'b1 || ws_result !== exps[i]) begin
                n_fails++; $display("FAIL subword[%0d]: got valid=%b result=%h want 1 %h",
                                    i, bus_if.ms_to_ws_valid, ws_result, exps[i]);
            end
        end
        @(posedge clk); #1;
        bus_if.data_sram_data_ok = 1'b0;
    endtask

    task automatic test_buffer();
        @(posedge clk); #1;
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk_es(3'd0, 1'b1, 1'b1, 5'd9, 32'h2000, 32'h1c000200);
        @(posedge clk); #1;
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.ws_allowin        = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b1 || ws_result !== 32'hDEADBEEF || ld_blk !== 1'b0) begin
            n_fails++; $display("FAIL buf_capture: got valid=%b result=%h blk=%b want 1 deadbeef 0",
                                bus_if.ms_to_ws_valid, ws_result, ld_blk);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus_if.data_sram_data_ok = 1'b0;
            bus_if.data_sram_rdata   = 32'h55555555 + c;
            #1;
            n_checks++;
            if (bus_if.ms_to_ws_valid !== 1'b1 || ws_result !== 32'hDEADBEEF || ld_blk !== 1'b0
                || bus_if.ms_allowin !== 1'b0) begin
                n_fails++; $display("FAIL buf_hold[%0d]: got valid=%b result=%h blk=%b allowin=%b want 1 deadbeef 0 0",
                                    c, bus_if.ms_to_ws_valid, ws_result, ld_blk, bus_if.ms_allowin);
            end
        end
        // WB releases and a new load enters in the same cycle.
        @(posedge clk); #1;
        bus_if.ws_allowin     = 1'b1;
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk_es(3'd0, 1'b1, 1'b1, 5'd10, 32'h3000, 32'h1c000204);
        #1;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b1 || ws_result !== 32'hDEADBEEF || bus_if.ms_allowin !== 1'b1) begin
            n_fails++; $display("FAIL buf_handoff: got valid=%b result=%h allowin=%b want 1 deadbeef 1",
                                bus_if.ms_to_ws_valid, ws_result, bus_if.ms_allowin);
        end
        @(posedge clk); #1;
        bus_if.es_to_ms_valid = 1'b0;
        #1;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b0 || ld_blk !== 1'b1 || fwd_we !== 1'b1) begin
            n_fails++; $display("FAIL buf_next_wait: got valid=%b blk=%b we=%b want 0 1 1",
                                bus_if.ms_to_ws_valid, ld_blk, fwd_we);
        end
        @(posedge clk); #1;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b1 || ws_result !== 32'hCAFEF00D || ws_pc !== 32'h1c000204) begin
            n_fails++; $display("FAIL buf_next_go: got valid=%b result=%h pc=%h want 1 cafef00d 1c000204",
                                bus_if.ms_to_ws_valid, ws_result, ws_pc);
        end
        @(posedge clk); #1;
        bus_if.data_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk_es(3'd0, 1'b1, 1'b1, 5'd12, 32'h4000, 32'h1c000300);
        @(posedge clk); #1;
        bus_if.es_to_ms_valid = 1'b0;
        #1;
        n_checks++;
        if (ld_blk !== 1'b1) begin
            n_fails++; $display("FAIL rst_pre_wait: got blk=%b want 1", ld_blk);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (bus_if.ms_to_ws_valid !== 1'b0 || bus_if.ms_allowin !== 1'b1 || ld_blk !== 1'b0 || fwd_we !== 1'b0) begin
            n_fails++; $display("FAIL rst_async: got valid=%b allowin=%b blk=%b we=%b want 0 1 0 0",
                                bus_if.ms_to_ws_valid, bus_if.ms_allowin, ld_blk, fwd_we);
        end
        #2 resetn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            bus_if.data_sram_data_ok = (c == 0);
            bus_if.data_sram_rdata   = 32'hBAADF00D;
            #1;
            n_checks++;
            if (bus_if.ms_to_ws_valid !== 1'b0 || fwd_we !== 1'b0) begin
                n_fails++; $display("FAIL rst_stray[%0d]: got valid=%b we=%b want 0 0",
                                    c, bus_if.ms_to_ws_valid, fwd_we);
            end
        end
        bus_if.data_sram_data_ok = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_back_to_back();
        test_load_wait();
        test_subword();
        test_buffer();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Pipelined memory-access stage for the five-stage LoongArch core, replacing the multicycle state-driven memory stage. It sits between EX and WB and uses a valid/allowin handshake on both sides. It waits for an SRAM-like data response (`data_ok`) on loads and buffers the returned word while WB back-pressures. It extracts and sign- or zero-extends sub-word load data, and publishes a forwarding/blocking bus back to ID.

## Interface
Parameters:
- `RF_AW`, default 5: register-file address width.
- `PC_W`, default 32: PC and ALU-result width. Must be ≥ 2. The data word is fixed at 32 bits.
- `ES_BUS_W`, default `5+RF_AW+2*PC_W`: EX→MS bus width (derived, do not override).
- `MS_BUS_W`, default `1+RF_AW+32+PC_W`: MS→WB bus width (derived).

Ports:
- `clk`  in  1: clock. One clock domain; reset is asynchronous and active-low.
- `resetn`  in  1: asynchronous active-low reset.
- `es_to_ms_valid`  in  1: EX holds a valid instruction.
- `ms_allowin`  out  1: MS can accept this cycle.
- `es_to_ms_bus`  in  `ES_BUS_W`: fields, MSB first, are `{mem_op[2:0], ld_req, gr_we, dest[RF_AW-1:0], alu_result[PC_W-1:0], pc[PC_W-1:0]}`.
- `ms_to_ws_valid`  out  1: MS is presenting a completed instruction.
- `ws_allowin`  in  1: WB can accept.
- `ms_to_ws_bus`  out  `MS_BUS_W`: fields are `{gr_we, dest, final_result[31:0], pc}`.
- `data_sram_data_ok`  in  1: load data response strobe.
- `data_sram_rdata`  in  32: load data, valid while `data_ok` is high.
- `ms_fwd_bus`  out  `2+RF_AW+32`: fields are `{fwd_we, ld_blk, dest, final_result}`.

## Operation
- State:
  - `ms_valid`.
  - `bus_r` (latched EX bus).
  - `rbuf[31:0]`.
  - `rbuf_vld`.
- Wait rule: `ms_wait = ms_valid & ld_req & ~rbuf_vld`.
- Go rule: `ms_ready_go = ~ms_wait | data_sram_data_ok`.
- `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_valid = ms_valid & ms_ready_go`.
- Accept: on `es_to_ms_valid & ms_allowin`, `bus_r <= es_to_ms_bus` and `ms_valid <= 1`. Otherwise, if `ms_ready_go & ws_allowin`, `ms_valid <= 0`.
- `bus_r` holds its value when no entry is accepted.
- Response capture: if `ms_wait & data_ok & ~ws_allowin`, then `rbuf <= rdata` and `rbuf_vld <= 1`. `rbuf_vld` clears when the entry leaves.
- Load word selection:
  - `rbuf` when `rbuf_vld`.
  - Otherwise `data_sram_rdata` directly (zero-latency path).
- `mem_op` decode:
  - 000: ld.w.
  - 001: ld.b, sign-extended.
  - 010: ld.h, sign-extended.
  - 011: ld.bu, zero-extended.
  - 100: ld.hu, zero-extended.
  - 101–111: treated as ld.w.
- Lane selection: byte lane is `alu_result[1:0]`; halfword lane is `alu_result[1]` (0 = low half). Misalignment is not checked; `alu_result[0]` is ignored for halfwords.
- `final_result` is the extended load word when `ld_req`, else `alu_result[31:0]`. If `PC_W > 32`, the upper bits are dropped; if `PC_W < 32`, the value is zero-extended.
- Forwarding bus:
  - `fwd_we = ms_valid & gr_we`.
  - `ld_blk = ms_wait & ~data_ok`: ID must stall on a dest match.
- `data_ok` while `~ms_wait` (idle, non-load, or already buffered) is ignored.

## Timing
- Reset (async assert): `ms_valid=0` and `rbuf_vld=0`, so `ms_to_ws_valid=0`, `ms_allowin=1`, `fwd_we=0`, `ld_blk=0`. `bus_r` and `rbuf` are cleared to 0.
- Non-load latency: 1 cycle in MS; throughput is 1 per cycle when `ws_allowin=1`.
- Load latency: leaves in the first cycle with `data_ok`, the earliest being the cycle the entry becomes valid. Each cycle without `data_ok` adds 1.
- If `data_ok` arrives with `ws_allowin=0`, the data is captured. The stage presents `ms_to_ws_valid=1` every cycle until WB accepts, and `ld_blk` stays 0.
- Simultaneous leave and accept: new entry latched, `ms_valid` stays 1, `rbuf_vld` cleared.
- `resetn` deasserted mid-wait: pending entry discarded; a late `data_ok` is ignored.
- `ms_to_ws_bus` and `ms_fwd_bus` are combinational from registers and `data_sram_rdata`; there are no registered outputs.

## Configuration
- `MS_SUBWORD_EN` defined: full `mem_op` decode as above.
- Not defined: `mem_op` is ignored; every load returns the raw 32-bit word, and the extension and lane logic is omitted.

## Test plan
- Back-to-back ALU ops (pcs 0x1c000000, 0x1c000004, 0x1c000008), `ws_allowin=1` -> one `ms_to_ws_valid` per cycle, `final_result = alu_result`, `ms_allowin` constantly 1.
- ld.w, `data_ok` 3 cycles after entry with rdata 0x12345678 -> `ld_blk=1` for 3 cycles, `ms_allowin=0`, then result 0x12345678 handed off in the `data_ok` cycle.
- ld.b at addr[1:0]=3, rdata 0x80AABBCC -> result 0xFFFFFF80. ld.hu at addr[1]=1, same rdata -> 0x000080AA.
- `data_ok` with rdata 0xDEADBEEF while `ws_allowin=0` for 4 cycles -> `rbuf_vld=1`, output holds 0xDEADBEEF, and a bus change on `data_sram_rdata` has no effect. Handoff occurs when `ws_allowin` rises.
- `resetn` pulsed low during a load wait, then a stray `data_ok` -> `ms_valid` stays 0 and no `ms_to_ws_valid` is produced.
- `MS_SUBWORD_EN` undefined, ld.b with rdata 0x80AABBCC -> result 0x80AABBCC.
